// File: rtl/bcd_ascii_tx.sv
// Sends a packed BCD value as ASCII decimal text (MSD first, then CR LF) on an 8N1 serial line.
// Define BCD_ASCII_TX_LZB_EN to skip leading zero digits (the LSD is always sent).
module bcd_ascii_tx #(
    parameter int DIGITS   = 4,
    parameter int BAUD_DIV = 104
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  START,
    output logic                  TXD,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int IW = $clog2(DIGITS + 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS + 1);
    localparam logic [15:0]   BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP_BIT} state_t;

    state_t              state, state_n;
    logic [15:0]         baud_cnt, baud_n;
    logic [2:0]          bit_cnt, bit_n;
    logic [IW-1:0]       idx, idx_n;
    logic [IW-1:0]       start_idx;
    logic [4*DIGITS-1:0] snap, snap_n;
    logic [7:0]          shreg, shreg_n;
    logic                txd_n, done_n;
    logic                baud_end;

    // Character at message position i: digit, CR, or LF.
    function automatic logic [7:0] char_of(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i);
        logic [3:0] nib;
        logic [7:0] c;
        nib = 4'h0;
        if (int'(i) < DIGITS) begin
            nib = 4'(v >> (4 * (DIGITS - 1 - int'(i))));
            c   = (nib > 4'd9) ? 8'h3F : {4'h3, nib};
        end else if (int'(i) == DIGITS) begin
            c = 8'h0D;
        end else begin
            c = 8'h0A;
        end
        return c;
    endfunction

`ifdef BCD_ASCII_TX_LZB_EN
    // Index of the first digit to send: first nonzero (or invalid) nibble, never past the LSD.
    function automatic logic [IW-1:0] first_idx(input logic [4*DIGITS-1:0] v);
        logic [IW-1:0] f;
        logic          blank;
        f     = '0;
        blank = 1'b1;
        for (int i = 0; i < DIGITS - 1; i++) begin
            if (blank && v[4*(DIGITS-1-i) +: 4] == 4'h0)
                f = IW'(i + 1);
            else
                blank = 1'b0;
        end
        return f;
    endfunction

    assign start_idx = first_idx(D);
`else
    assign start_idx = '0;
`endif

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign BUSY     = (state != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_n = state;
        baud_n  = baud_cnt;
        bit_n   = bit_cnt;
        idx_n   = idx;
        snap_n  = snap;
        shreg_n = shreg;
        txd_n   = TXD;
        done_n  = 1'b0;

        case (state)
            IDLE: begin
                txd_n = 1'b1;
                if (START) begin
                    snap_n  = D;
                    idx_n   = start_idx;
                    shreg_n = char_of(D, start_idx);
                    baud_n  = '0;
                    txd_n   = 1'b0;
                    state_n = START_BIT;
                end
            end
            START_BIT: begin
                if (baud_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    txd_n   = shreg[0];
                    state_n = DATA;
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (bit_cnt == 3'd7) begin
                        txd_n   = 1'b1;
                        state_n = STOP_BIT;
                    end else begin
                        bit_n   = bit_cnt + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        txd_n   = shreg[1];
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            STOP_BIT: begin
                if (baud_end) begin
                    baud_n = '0;
                    if (idx == LAST_IDX) begin
                        txd_n   = 1'b1;
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        // Next character's start bit begins on this same edge.
                        idx_n   = idx + IW'(1);
                        shreg_n = char_of(snap, idx + IW'(1));
                        txd_n   = 1'b0;
                        state_n = START_BIT;
                    end
                end else begin
                    baud_n = baud_cnt + 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            snap     <= '0;
            shreg    <= '0;
            TXD      <= 1'b1;
            DONE     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values from the block above.
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_cnt  <= bit_n;
            idx      <= idx_n;
            snap     <= snap_n;
            shreg    <= shreg_n;
            TXD      <= txd_n;
            DONE     <= done_n;
        end
    end

endmodule

// File: tb/tb_bcd_ascii_tx.sv
// Directed self-checking bench for bcd_ascii_tx with DIGITS=4, BAUD_DIV=4.
// Expectations follow BCD_ASCII_TX_LZB_EN when that macro is defined for the build.
module tb_bcd_ascii_tx;

    localparam int BD = 4;

    logic        CLK = 1'b0;
    logic        CLR;
    logic [15:0] D;
    logic        START;
    logic        TXD, BUSY, DONE;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_chars [0:5];
    int         exp_n;
    bit         hold_run;

    bcd_ascii_tx #(.DIGITS(4), .BAUD_DIV(BD)) dut (
        .CLK(CLK), .CLR(CLR), .D(D), .START(START),
        .TXD(TXD), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [7:0] c0, c1, c2, c3, c4, c5, input int n);
        exp_chars[0] = c0; exp_chars[1] = c1; exp_chars[2] = c2;
        exp_chars[3] = c3; exp_chars[4] = c4; exp_chars[5] = c5;
        exp_n = n;
    endtask

    // Full-width expectation for values whose top digit is nonzero (blanking has no effect).
    task automatic set_exp_from(input logic [15:0] d);
        logic [3:0] nib;
        for (int i = 0; i < 4; i++) begin
            nib = d[4*(3-i) +: 4];
            exp_chars[i] = (nib > 4'd9) ? 8'h3F : (8'h30 + {4'h0, nib});
        end
        exp_chars[4] = 8'h0D;
        exp_chars[5] = 8'h0A;
        exp_n = 6;
    endtask

    task automatic start_pulse(input logic [15:0] d, input string tag);
        @(negedge CLK);
        D     = d;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check({tag, " accept busy"}, BUSY, 1);
        check({tag, " accept txd"}, TXD, 0);
    endtask

    // Entered #1 after the accept edge; returns #1 after the edge where BUSY falls.
    task automatic recv_msg(input string tag);
        logic txd_hist [0:1023];
        int   busy_len, done_seen, done_at, glitches;
        logic [7:0] got;
        logic       sb, pb;
        busy_len = -1; done_seen = 0; done_at = -1; glitches = 0;
        for (int c = 0; c < 1000; c++) begin
            txd_hist[c] = TXD;
            if (DONE) begin
                done_seen++;
                done_at = c;
            end
            if (!BUSY) begin
                busy_len = c;
                break;
            end
            @(posedge CLK);
            #1;
        end
        check({tag, " busy_len"}, busy_len, exp_n * 10 * BD);
        check({tag, " done_cnt"}, done_seen, 1);
        check({tag, " done_at"}, done_at, exp_n * 10 * BD);
        if (busy_len >= 0) check({tag, " txd_end"}, TXD, 1);
        for (int j = 0; j < exp_n; j++) begin
            got = '0;
            for (int b = 0; b < 10; b++) begin
                for (int s = 0; s < BD; s++)
                    if (txd_hist[(j*10+b)*BD+s] !== txd_hist[(j*10+b)*BD+BD/2]) glitches++;
            end
            sb = txd_hist[(j*10)*BD + BD/2];
            pb = txd_hist[(j*10+9)*BD + BD/2];
            for (int b = 0; b < 8; b++) got[b] = txd_hist[(j*10+1+b)*BD + BD/2];
            check($sformatf("%s ch%0d", tag, j), got, exp_chars[j]);
            check($sformatf("%s frame%0d", tag, j), {pb, sb}, 2'b10);
        end
        check({tag, " bit_stable"}, glitches, 0);
    endtask

    initial begin
        int anomalies;
        CLR = 1'b0; START = 1'b0; D = '0; hold_run = 1'b0;
        #12;
        check("reset txd", TXD, 1);
        check("reset busy", BUSY, 0);
        check("reset done", DONE, 0);
        @(negedge CLK);
        CLR = 1'b1;

`ifdef BCD_ASCII_TX_LZB_EN
        set_exp(8'h39, 8'h37, 8'h35, 8'h0D, 8'h0A, 8'h00, 5);
`else
        set_exp(8'h30, 8'h39, 8'h37, 8'h35, 8'h0D, 8'h0A, 6);
`endif
        start_pulse(16'h0975, "m0975");
        recv_msg("m0975");

`ifdef BCD_ASCII_TX_LZB_EN
        set_exp(8'h30, 8'h0D, 8'h0A, 8'h00, 8'h00, 8'h00, 3);
`else
        set_exp(8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A, 6);
`endif
        start_pulse(16'h0000, "m0000");
        recv_msg("m0000");

        set_exp(8'h31, 8'h3F, 8'h32, 8'h39, 8'h0D, 8'h0A, 6);
        start_pulse(16'h1A29, "m1A29");
        recv_msg("m1A29");

        // START raised during the DONE cycle is taken on the very next edge.
        START = 1'b1;
        D     = 16'h2468;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("done_cycle busy", BUSY, 1);
        check("done_cycle txd", TXD, 0);
        set_exp(8'h32, 8'h34, 8'h36, 8'h38, 8'h0D, 8'h0A, 6);
        recv_msg("m2468");

        // START held high with D changing every clock.
        @(negedge CLK);
        D        = 16'h1234;
        START    = 1'b1;
        hold_run = 1'b1;
        fork
            begin
                logic [15:0] seq [0:3];
                int k;
                seq[0] = 16'h5678; seq[1] = 16'h9012; seq[2] = 16'h3456; seq[3] = 16'h7890;
                k = 0;
                while (hold_run) begin
                    @(negedge CLK);
                    if (hold_run) D = seq[k % 4];
                    k++;
                end
            end
        join_none
        @(posedge CLK);
        #1;
        set_exp_from(D);
        check("hold1 value", D, 16'h1234);
        recv_msg("hold1");
        @(posedge CLK);
        #1;
        check("hold2 busy", BUSY, 1);
        check("hold2 txd", TXD, 0);
        set_exp_from(D);
        recv_msg("hold2");
        START    = 1'b0;
        hold_run = 1'b0;

        // Asynchronous reset during a data bit of the third character.
        start_pulse(16'h0975, "rst");
        repeat (2*10*BD + 3*BD + 1) @(posedge CLK);
        #4;
        CLR = 1'b0;
        #1;
        check("rst txd", TXD, 1);
        check("rst busy", BUSY, 0);
        check("rst done", DONE, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        CLR = 1'b1;
        anomalies = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (BUSY !== 1'b0 || TXD !== 1'b1 || DONE !== 1'b0) anomalies++;
        end
        check("post_rst idle", anomalies, 0);

`ifdef BCD_ASCII_TX_LZB_EN
        set_exp(8'h39, 8'h37, 8'h35, 8'h0D, 8'h0A, 8'h00, 5);
`else
        set_exp(8'h30, 8'h39, 8'h37, 8'h35, 8'h0D, 8'h0A, 6);
`endif
        start_pulse(16'h0975, "after_rst");
        recv_msg("after_rst");

        repeat (4) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcd_ascii_tx.md
Name: bcd_ascii_tx

Overview:
- Downstream consumer of the BCD adder/counter/latch chain.
- Takes the packed multi-digit BCD result held in the output register and transmits it over the RS232 TXD line as ASCII decimal text, most significant digit first, terminated by CR LF.
- Runs on the single system clock, with an internal baud divider and 8N1 framing.

Parameters:
- DIGITS, 4, number of BCD digits in D (D width = 4*DIGITS).
- BAUD_DIV, 104, clocks per serial bit (range 2..65535).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- CLR  input  1  asynchronous reset, active low (0 = reset).
- D  input  4*DIGITS  packed BCD value, digit DIGITS-1 in the top nibble; sampled only on an accepted START.
- START  input  1  request to send D; level sampled each CLK.
- TXD  output  1  serial data, idle high.
- BUSY  output  1  high while a message is in progress.
- DONE  output  1  one-clock pulse at end of message.

Behaviour:
- Reset (CLR=0, asynchronous): TXD=1, BUSY=0, DONE=0, FSM=IDLE, all counters and the digit snapshot cleared. Takes effect immediately, including mid-bit or mid-message. No partial frame resumes after release.
- Start acceptance:
  - START=1 at a rising edge with BUSY=0 is accepted. D is copied into an internal snapshot at that edge.
  - From the same edge: BUSY=1 and TXD=0 (start bit of the first character).
  - START while BUSY=1 is ignored and not queued.
- Character sequence: DIGITS digit characters, MSD first, then 0x0D, then 0x0A.
- Digit encoding:
  - Nibble 0..9 is sent as 0x30+nibble.
  - Nibble 0xA..0xF is sent as 0x3F ('?'). This is an error marker; no other action is taken.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit holds TXD for exactly BAUD_DIV clocks. Characters are back-to-back with no idle gap.
- FSM states and transitions:
  - IDLE -> START_BIT on an accepted START.
  - START_BIT -> DATA after BAUD_DIV clocks.
  - DATA: 8 bits, BAUD_DIV clocks each, 3-bit bit counter, then -> STOP_BIT.
  - STOP_BIT: after BAUD_DIV clocks, go to NEXT (load the next character; its start bit begins on that same edge) or to IDLE if the character just sent was LF.
- Message length: (DIGITS+2)*10*BAUD_DIV clocks from the accept edge to the edge where BUSY falls.
- Completion:
  - On the edge ending the LF stop bit: BUSY=0, DONE=1 for exactly one clock, TXD stays 1.
  - START=1 in that same DONE cycle is accepted, so back-to-back messages are separated by 0 idle clocks.
- Width rules:
  - Baud counter is 16 bits and counts 0..BAUD_DIV-1.
  - Character index counter is wide enough for DIGITS+2 values.
  - No arithmetic is performed on D beyond the nibble compare (>9) and OR with 0x30.

Optional Feature:
- Macro BCD_ASCII_TX_LZB_EN (leading-zero blanking).
- Defined:
  - Leading 0 nibbles of the snapshot are skipped entirely; no character is sent for them.
  - The LSD is always sent, so an all-zero value sends "0".
  - An invalid nibble ends blanking.
  - Message length becomes (sent_digits+2)*10*BAUD_DIV.
  - Skipping causes no extra idle time: the first sent character's start bit begins on the accept edge.
- Undefined: all DIGITS characters are always sent, with zeros sent as 0x30.

Test Plan (DIGITS=4, BAUD_DIV=4):
- D=16'h0975, pulse START -> TXD carries 0x30,0x39,0x37,0x35,0x0D,0x0A in 8N1. BUSY high exactly 240 clocks. DONE one pulse as BUSY falls. With LZB_EN: 0x39,0x37,0x35,0x0D,0x0A and 200 clocks.
- D=16'h0000 -> "0000" CR LF (240 clocks). With LZB_EN: 0x30,0x0D,0x0A (120 clocks).
- D=16'h1A29 -> 0x31,0x3F,0x32,0x39,0x0D,0x0A. DONE as normal.
- START held high continuously with D changing every clock -> messages are back-to-back with 0 idle clocks. Each message reflects D sampled at its own accept edge. Pulses during BUSY do not alter the message in flight.
- CLR=0 asserted mid-data-bit of the third character, asynchronously between clock edges -> TXD=1 and BUSY=0 immediately. No DONE pulse. After release, idle until a new START, and the next message is complete and correct.
- START asserted in the DONE cycle -> accepted. TXD=0 on that same edge. The second message is bit-exact to the expected sequence.
